// File: rtl/mix_columns_engine.sv
// Handshaked, column-serial AES MixColumns engine (LANES columns per cycle) with bypass.
// Define MIX_COLUMNS_INV_EN to build the InvMixColumns datapath selected by in_inverse.
module mix_columns_engine #(
    parameter int LANES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_bypass,
    input  logic         in_inverse,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_lanes_chk
        $error("mix_columns_engine: LANES must be 1, 2 or 4");
    end

    localparam logic [1:0] COL_STEP = 2'(LANES);
    localparam logic [1:0] COL_LAST = 2'(4 - LANES);

    typedef enum logic [1:0] {IDLE, PROC, DONE} state_t;

    state_t       state_q, state_d;
    logic [1:0]   col_cnt_q, col_cnt_d;
    logic [127:0] work_q, work_d;
    logic         bypass_q;
    logic         load, step;
    logic [1:0]   lane_col [LANES];
    logic [31:0]  lane_res [LANES];

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] x);
        return xtime(x) ^ x;
    endfunction

    function automatic logic [31:0] fwd_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ mul3(a1) ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ mul3(a2) ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ mul3(a3),
                mul3(a0) ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

`ifdef MIX_COLUMNS_INV_EN
    logic inverse_q;

    // Inverse coefficients built from x2/x4/x8 partial products.
    function automatic logic [7:0] mul9(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ x;
    endfunction

    function automatic logic [7:0] mulb(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
    endfunction

    function automatic logic [7:0] muld(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
    endfunction

    function automatic logic [7:0] mule(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
    endfunction

    function automatic logic [31:0] inv_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3),
                mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3),
                muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3),
                mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3)};
    endfunction
`else
    logic unused_in_inverse;
    assign unused_in_inverse = in_inverse;
`endif

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [31:0] col_in;
        assign lane_col[l] = col_cnt_q + 2'(l);
        assign col_in      = work_q[7'd127 - {lane_col[l], 5'd0} -: 32];
`ifdef MIX_COLUMNS_INV_EN
        assign lane_res[l] = inverse_q ? inv_col(col_in) : fwd_col(col_in);
`else
        assign lane_res[l] = fwd_col(col_in);
`endif
    end

    always_comb begin
        work_d = work_q;
        for (int l = 0; l < LANES; l++) begin
            work_d[7'd127 - {lane_col[l], 5'd0} -: 32] = lane_res[l];
        end
    end

    // Bypass still spends one cycle in PROC (without writing) so its latency is one cycle.
    always_comb begin
        state_d   = state_q;
        col_cnt_d = col_cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        load      = 1'b0;
        step      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    load      = 1'b1;
                    col_cnt_d = 2'd0;
                    state_d   = PROC;
                end
            end
            PROC: begin
                if (bypass_q) begin
                    state_d = DONE;
                end else begin
                    step      = 1'b1;
                    col_cnt_d = col_cnt_q + COL_STEP;
                    if (col_cnt_q == COL_LAST) state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            col_cnt_q <= 2'd0;
        end else begin
            state_q   <= state_d;
            col_cnt_q <= col_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            work_q   <= in_state;
            bypass_q <= in_bypass;
`ifdef MIX_COLUMNS_INV_EN
            inverse_q <= in_inverse;
`endif
        end else if (step) begin
            work_q <= work_d;
        end
    end

    assign out_state = out_valid ? work_q : 128'd0;

endmodule

// File: tb/tb_mix_columns_engine.sv
// Directed bench for mix_columns_engine: three instances (LANES = 1, 2, 4) share stimulus.
module tb_mix_columns_engine;

    localparam logic [127:0] FWD_IN   = 128'hdb135345_f20a225c_01010101_2d26314c;
    localparam logic [127:0] FWD_OUT  = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
    localparam logic [127:0] BYP_IN   = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] FWD2_OUT = 128'hcd504506_9f494f1f_01010101_5d9541ff;
    localparam logic [127:0] ALT_IN   = 128'h0f0e0d0c_0b0a0908_07060504_03020100;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [127:0] in_state;
    logic         in_bypass;
    logic         in_inverse;
    logic         out_ready;
    logic [2:0]   ir, ov, bz;
    logic [127:0] os [3];

    int checks;
    int passes;
    int fails;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mix_columns_engine #(.LANES(1 << g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (ir[g]),
            .in_state  (in_state),
            .in_bypass (in_bypass),
            .in_inverse(in_inverse),
            .out_valid (ov[g]),
            .out_ready (out_ready),
            .out_state (os[g]),
            .busy      (bz[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input string tag, input logic [127:0] st, input logic byp,
                         input logic inv, input logic [127:0] exp,
                         input int l0, input int l1, input int l2);
        int lat [3];
        int exp_lat [3];
        exp_lat[0] = l0;
        exp_lat[1] = l1;
        exp_lat[2] = l2;
        for (int g = 0; g < 3; g++) lat[g] = 0;
        in_state   = st;
        in_bypass  = byp;
        in_inverse = inv;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        @(posedge clk); #1;
        // Scramble inputs after accept: the state in flight must not notice.
        in_valid   = 1'b0;
        in_bypass  = ~byp;
        in_inverse = ~inv;
        in_state   = ALT_IN;
        chk({tag, "_busy"}, 128'(bz), 128'(3'b111));
        chk({tag, "_inrdy_low"}, 128'(ir), 128'(3'b000));
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            for (int g = 0; g < 3; g++) begin
                if (lat[g] == 0) begin
                    if (ov[g]) begin
                        lat[g] = k;
                        chk($sformatf("%s_state_L%0d", tag, 1 << g), os[g], exp);
                    end else begin
                        chk($sformatf("%s_inrdy_L%0d", tag, 1 << g), 128'(ir[g]), 128'(1'b0));
                    end
                end
            end
        end
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("%s_latency_L%0d", tag, 1 << g), 128'(lat[g]), 128'(exp_lat[g]));
        end
        chk({tag, "_idle_after"}, 128'(ir), 128'(3'b111));
        in_bypass  = 1'b0;
        in_inverse = 1'b0;
    endtask

    initial begin
        checks     = 0;
        passes     = 0;
        fails      = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_state   = '0;
        in_bypass  = 1'b0;
        in_inverse = 1'b0;
        out_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", 128'(ir), 128'(3'b111));
        chk("rst_out_valid", 128'(ov), 128'(3'b000));
        chk("rst_busy", 128'(bz), 128'(3'b000));
        for (int g = 0; g < 3; g++) chk($sformatf("rst_out_state_L%0d", 1 << g), os[g], 128'd0);

        do_op("fwd", FWD_IN, 1'b0, 1'b0, FWD_OUT, 4, 2, 1);
        do_op("byp", BYP_IN, 1'b1, 1'b0, BYP_IN, 1, 1, 1);
`ifdef MIX_COLUMNS_INV_EN
        do_op("inv", FWD_OUT, 1'b0, 1'b1, FWD_IN, 4, 2, 1);
`else
        do_op("inv", FWD_OUT, 1'b0, 1'b1, FWD2_OUT, 4, 2, 1);
`endif

        // Backpressure: result must hold while out_ready stays low.
        in_state  = FWD_IN;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            in_state = (i % 2 == 0) ? ALT_IN : BYP_IN;
            @(posedge clk); #1;
            chk($sformatf("bp_out_valid_%0d", i), 128'(ov), 128'(3'b111));
            chk($sformatf("bp_in_ready_%0d", i), 128'(ir), 128'(3'b000));
            for (int g = 0; g < 3; g++) chk($sformatf("bp_state_L%0d_%0d", 1 << g, i), os[g], FWD_OUT);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_in_ready", 128'(ir), 128'(3'b111));
        chk("bp_release_out_valid", 128'(ov), 128'(3'b000));

        // Reset in the middle of PROC (LANES=1 instance has col_cnt = 2).
        in_state = FWD_IN;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_busy_L1", 128'(bz[0]), 128'(1'b1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_out_valid", 128'(ov), 128'(3'b000));
        chk("mid_rst_busy", 128'(bz), 128'(3'b000));
        chk("mid_rst_in_ready", 128'(ir), 128'(3'b111));
        for (int g = 0; g < 3; g++) chk($sformatf("mid_rst_state_L%0d", 1 << g), os[g], 128'd0);
        do_op("post_rst", FWD_IN, 1'b0, 1'b0, FWD_OUT, 4, 2, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
